// File: rtl/ysyx_210544_wb_arbiter.sv
// Writeback arbiter: shares the regfile write port and commit outputs between the
// in-order pipeline (A, fixed priority) and the mul/div unit (B, anti-starvation).
module ysyx_210544_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_req,
  output logic        o_a_ack,
  input  logic [63:0] i_a_pc,
  input  logic [31:0] i_a_inst,
  input  logic [4:0]  i_a_rd,
  input  logic        i_a_rd_wen,
  input  logic [63:0] i_a_rd_wdata,
  input  logic        i_a_skipcmt,
  input  logic [31:0] i_a_intrNo,
  input  logic        i_b_req,
  output logic        o_b_ack,
  input  logic [63:0] i_b_pc,
  input  logic [31:0] i_b_inst,
  input  logic [4:0]  i_b_rd,
  input  logic [63:0] i_b_rd_wdata,
  output logic [4:0]  o_rf_rd,
  output logic        o_rf_wen,
  output logic [63:0] o_rf_wdata,
  output logic        o_cmt_valid,
  output logic [63:0] o_cmt_pc,
  output logic [31:0] o_cmt_inst,
  output logic        o_cmt_skipcmt,
  output logic [31:0] o_cmt_intrNo,
  output logic [31:0] o_conflict_cnt
);

  function automatic logic rf_wen_gate(input logic wen, input logic [4:0] rd);
    return wen && (rd != 5'd0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             grant_a, grant_b;

  logic [4:0]  rf_rd_p0;
  logic        rf_wen_p0;
  logic [63:0] rf_wdata_p0;
  logic        vld_p0;
  logic [63:0] cmt_pc_p0;
  logic [31:0] cmt_inst_p0;
  logic        cmt_skipcmt_p0;
  logic [31:0] cmt_intrNo_p0;

  logic [4:0]  rf_rd_p1;
  logic        rf_wen_p1;
  logic [63:0] rf_wdata_p1;
  logic        vld_p1;
  logic [63:0] cmt_pc_p1;
  logic [31:0] cmt_inst_p1;
  logic        cmt_skipcmt_p1;
  logic [31:0] cmt_intrNo_p1;
  logic [31:0] conflict_cnt;

  // p0: grant decision and selection of the winning requester's fields
  assign starve_hit = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst) begin
      if (i_b_req && (!i_a_req || starve_hit)) grant_b = 1'b1;
      else if (i_a_req)                        grant_a = 1'b1;
    end
  end

  assign o_a_ack = grant_a;
  assign o_b_ack = grant_b;

  always_comb begin
    rf_rd_p0       = 5'd0;
    rf_wen_p0      = 1'b0;
    rf_wdata_p0    = 64'd0;
    vld_p0         = 1'b0;
    cmt_pc_p0      = 64'd0;
    cmt_inst_p0    = 32'd0;
    cmt_skipcmt_p0 = 1'b0;
    cmt_intrNo_p0  = 32'd0;
    if (grant_a) begin
      rf_rd_p0       = i_a_rd;
      rf_wen_p0      = rf_wen_gate(i_a_rd_wen, i_a_rd);
      rf_wdata_p0    = i_a_rd_wdata;
      vld_p0         = 1'b1;
      cmt_pc_p0      = i_a_pc;
      cmt_inst_p0    = i_a_inst;
      cmt_skipcmt_p0 = i_a_skipcmt;
      cmt_intrNo_p0  = i_a_intrNo;
    end else if (grant_b) begin
      rf_rd_p0       = i_b_rd;
      rf_wen_p0      = rf_wen_gate(1'b1, i_b_rd);
      rf_wdata_p0    = i_b_rd_wdata;
      vld_p0         = 1'b1;
      cmt_pc_p0      = i_b_pc;
      cmt_inst_p0    = i_b_inst;
    end
  end

  // p1: registered writeback/commit outputs; an idle cycle registers all zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_rd_p1       <= 5'd0;
      rf_wen_p1      <= 1'b0;
      rf_wdata_p1    <= 64'd0;
      vld_p1         <= 1'b0;
      cmt_pc_p1      <= 64'd0;
      cmt_inst_p1    <= 32'd0;
      cmt_skipcmt_p1 <= 1'b0;
      cmt_intrNo_p1  <= 32'd0;
      starve_cnt     <= '0;
      conflict_cnt   <= 32'd0;
    end else begin
      rf_rd_p1       <= rf_rd_p0;
      rf_wen_p1      <= rf_wen_p0;
      rf_wdata_p1    <= rf_wdata_p0;
      vld_p1         <= vld_p0;
      cmt_pc_p1      <= cmt_pc_p0;
      cmt_inst_p1    <= cmt_inst_p0;
      cmt_skipcmt_p1 <= cmt_skipcmt_p0;
      cmt_intrNo_p1  <= cmt_intrNo_p0;
      if (grant_b || !i_b_req) starve_cnt <= '0;
      else                     starve_cnt <= sat_inc(starve_cnt);
      if (i_a_req && i_b_req)  conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign o_rf_rd        = rf_rd_p1;
  assign o_rf_wen       = rf_wen_p1;
  assign o_rf_wdata     = rf_wdata_p1;
  assign o_cmt_valid    = vld_p1;
  assign o_cmt_pc       = cmt_pc_p1;
  assign o_cmt_inst     = cmt_inst_p1;
  assign o_cmt_skipcmt  = cmt_skipcmt_p1;
  assign o_cmt_intrNo   = cmt_intrNo_p1;
  assign o_conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_ysyx_210544_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the grant/commit rules.
module tb_ysyx_210544_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, a_ack, a_wen, a_skip;
  logic [63:0] a_pc, a_wdata;
  logic [31:0] a_inst, a_intr;
  logic [4:0]  a_rd;
  logic        b_req, b_ack;
  logic [63:0] b_pc, b_wdata;
  logic [31:0] b_inst;
  logic [4:0]  b_rd;
  logic [4:0]  rf_rd;
  logic        rf_wen, cmt_valid, cmt_skip;
  logic [63:0] rf_wdata, cmt_pc;
  logic [31:0] cmt_inst, cmt_intr, conf_cnt;

  ysyx_210544_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .o_a_ack(a_ack), .i_a_pc(a_pc), .i_a_inst(a_inst),
    .i_a_rd(a_rd), .i_a_rd_wen(a_wen), .i_a_rd_wdata(a_wdata),
    .i_a_skipcmt(a_skip), .i_a_intrNo(a_intr),
    .i_b_req(b_req), .o_b_ack(b_ack), .i_b_pc(b_pc), .i_b_inst(b_inst),
    .i_b_rd(b_rd), .i_b_rd_wdata(b_wdata),
    .o_rf_rd(rf_rd), .o_rf_wen(rf_wen), .o_rf_wdata(rf_wdata),
    .o_cmt_valid(cmt_valid), .o_cmt_pc(cmt_pc), .o_cmt_inst(cmt_inst),
    .o_cmt_skipcmt(cmt_skip), .o_cmt_intrNo(cmt_intr), .o_conflict_cnt(conf_cnt)
  );

  wire [199:0] obs = {rf_rd, rf_wen, rf_wdata, cmt_valid, cmt_pc, cmt_inst, cmt_skip, cmt_intr};

  int          checks = 0;
  int          failures = 0;
  int          deny = 0;
  logic [31:0] exp_conf = 32'd0;
  logic [199:0] exp_out = '0;
  logic [1:0]  g;

  // Reference: grant code {B,A} from current requests and B's waiting time.
  function automatic logic [1:0] predict();
    if (!rst) return 2'b00;
    if (a_req && b_req) return (deny >= LIMIT) ? 2'b10 : 2'b01;
    return {b_req, a_req};
  endfunction

  function automatic logic [199:0] expect_out(input logic [1:0] gr);
    if (gr[0]) return {a_rd, a_wen && (a_rd != 5'd0), a_wdata, 1'b1, a_pc, a_inst, a_skip, a_intr};
    if (gr[1]) return {b_rd, (b_rd != 5'd0), b_wdata, 1'b1, b_pc, b_inst, 1'b0, 32'd0};
    return '0;
  endfunction

  // Called right at the clock edge, before inputs change.
  task automatic advance(input logic [1:0] gr);
    if (!rst) begin
      exp_out = '0;
      deny = 0;
      return;
    end
    exp_out = expect_out(gr);
    if (b_req && !gr[1]) deny++;
    else deny = 0;
    if (a_req && b_req) exp_conf++;
  endtask

  task automatic set_a(input logic req, input logic [4:0] rd, input logic wen,
                       input logic [63:0] wd, input logic skip, input logic [31:0] intr);
    a_req = req; a_rd = rd; a_wen = wen; a_wdata = wd; a_skip = skip; a_intr = intr;
    a_pc = {$urandom, $urandom}; a_inst = $urandom;
  endtask

  task automatic set_b(input logic req, input logic [4:0] rd, input logic [63:0] wd);
    b_req = req; b_rd = rd; b_wdata = wd;
    b_pc = {$urandom, $urandom}; b_inst = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_a(1'b1, 5'd3, 1'b1, 64'h5, 1'b1, 32'd1);
    set_b(1'b1, 5'd4, 64'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL reset_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL reset_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL reset_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      @(posedge clk); advance(g); #1;
      if (i == 1) begin rst = 1'b1; set_b(1'b0, 5'd0, 64'd0); end
    end
    set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
  endtask

  task automatic test_a_only();
    logic [4:0]  rds [3] = '{5'd5, 5'd6, 5'd0};
    logic [63:0] wds [3] = '{64'h11, 64'h22, 64'h33};
    logic [2:0]  wen_seen = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_a(1'b1, rds[i], 1'b1, wds[i], 1'b0, 32'd0);
      else       set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL a_only_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL a_only_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL a_only_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      if (i >= 1 && i <= 3) wen_seen[i-1] = rf_wen;
      @(posedge clk); advance(g); #1;
    end
    checks++;
    if (wen_seen !== 3'b011) begin failures++; $display("FAIL a_only_wen_seq got=%b exp=011", wen_seen); end
  endtask

  task automatic test_b_only();
    set_a(1'b0, 5'd9, 1'b1, 64'h99, 1'b1, 32'h55);
    set_b(1'b1, 5'd10, 64'hDEAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL b_only_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL b_only_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL b_only_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      if (i == 1) begin
        checks++;
        if ({rf_wen, rf_rd, cmt_skip, cmt_intr, rf_wdata} !== {1'b1, 5'd10, 1'b0, 32'd0, 64'hDEAD}) begin
          failures++;
          $display("FAIL b_only_commit got wen=%b rd=%0d skip=%b intr=%0d wd=%h", rf_wen, rf_rd, cmt_skip, cmt_intr, rf_wdata);
        end
      end
      @(posedge clk); advance(g); #1;
      set_b(1'b0, 5'd0, 64'd0);
    end
  endtask

  task automatic test_contention();
    logic [31:0] c0 = exp_conf;
    logic [9:0]  bseq = '0;
    set_a(1'b1, 5'd1, 1'b1, 64'hA0, 1'b0, 32'd0);
    set_b(1'b1, 5'd1, 64'hB0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL contend_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL contend_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL contend_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      if (i < 10) bseq[i] = b_ack;
      if (i == 10) begin
        checks++;
        if (conf_cnt !== c0 + 32'd10) begin failures++; $display("FAIL contend_conf10 got=%0d exp=%0d", conf_cnt, c0 + 32'd10); end
      end
      @(posedge clk); advance(g); #1;
      if (i < 9) begin
        set_a(1'b1, 5'(i + 2), 1'b1, 64'(i), 1'b0, 32'd0);
        set_b(1'b1, 5'(i + 2), 64'(i + 100));
      end else begin
        set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
        set_b(1'b0, 5'd0, 64'd0);
      end
    end
    checks++;
    if (bseq !== 10'b1000010000) begin failures++; $display("FAIL contend_pattern got=%b exp=1000010000", bseq); end
  endtask

  task automatic test_starve_clear();
    logic [4:0] bseq = '0;
    for (int i = 0; i < 9; i++) begin
      set_a(1'b1, 5'd7, 1'b1, 64'(i), 1'b0, 32'd0);
      set_b(!(i == 2 || i == 8), 5'd8, 64'(i + 50));
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL starve_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL starve_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL starve_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      if (i >= 3 && i <= 7) bseq[i-3] = b_ack;
      @(posedge clk); advance(g); #1;
    end
    set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
    set_b(1'b0, 5'd0, 64'd0);
    checks++;
    if (bseq !== 5'b10000) begin failures++; $display("FAIL starve_wait got=%b exp=10000", bseq); end
  endtask

  task automatic test_idle_gap();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_a(1'b1, 5'd12, 1'b1, 64'h77, 1'b1, 32'd7);
      else        set_a(1'b0, 5'd12, 1'b1, 64'h77, 1'b1, 32'd7);
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL idle_ack got=%b exp=%b", {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL idle_out got=%h exp=%h", obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL idle_conf got=%0d exp=%0d", conf_cnt, exp_conf); end
      if (i == 1) begin
        checks++;
        if (cmt_intr !== 32'd7 || cmt_valid !== 1'b1) begin failures++; $display("FAIL idle_commit got intr=%0d vld=%b exp intr=7 vld=1", cmt_intr, cmt_valid); end
      end
      if (i == 2) begin
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL idle_zero got=%h exp=0", obs); end
      end
      @(posedge clk); advance(g); #1;
    end
  endtask

  task automatic test_reset_mid();
    set_a(1'b1, 5'd3, 1'b1, 64'h1, 1'b0, 32'd0);
    set_b(1'b1, 5'd4, 64'h2);
    @(posedge clk); advance(predict()); #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if ({b_ack, a_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_ack got=%b exp=00", {b_ack, a_ack}); end
    if (obs !== '0) begin failures++; $display("FAIL rstmid_out got=%h exp=0", obs); end
    if (conf_cnt !== 32'd0) begin failures++; $display("FAIL rstmid_conf got=%0d exp=0", conf_cnt); end
    exp_out = '0; deny = 0; exp_conf = 32'd0;
    @(posedge clk); advance(2'b00); #1;
    set_b(1'b0, 5'd0, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    g = predict();
    checks += 2;
    if ({b_ack, a_ack} !== 2'b01) begin failures++; $display("FAIL rstmid_first_ack got=%b exp=01", {b_ack, a_ack}); end
    if (obs !== '0) begin failures++; $display("FAIL rstmid_after got=%h exp=0", obs); end
    @(posedge clk); advance(g); #1;
    set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g = predict();
      checks += 3;
      if ({b_ack, a_ack} !== g) begin failures++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", i, {b_ack, a_ack}, g); end
      if (obs !== exp_out) begin failures++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", i, obs, exp_out); end
      if (conf_cnt !== exp_conf) begin failures++; $display("FAIL rand_conf cyc=%0d got=%0d exp=%0d", i, conf_cnt, exp_conf); end
      @(posedge clk); advance(g); #1;
      if (!a_req || g[0])
        set_a(($urandom % 10) < 7, 5'($urandom), $urandom % 2 == 1, {$urandom, $urandom}, $urandom % 2 == 1, $urandom);
      if (!b_req || g[1])
        set_b(($urandom % 10) < 6, 5'($urandom), {$urandom, $urandom});
    end
  endtask

  initial begin
    rst = 1'b0;
    set_a(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 32'd0);
    set_b(1'b0, 5'd0, 64'd0);
    test_reset();
    test_a_only();
    test_b_only();
    test_contention();
    test_starve_clear();
    test_idle_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
